// File: rtl/popcount_accum.sv
// -----------------------------------------------------------------------------
// popcount_accum
//   Streaming population-count accumulator. Words arrive on a valid/ready
//   stream and are grouped into frames by in_last. Stage 1 registers per-byte
//   ones counts. Stage 2 sums them into a word count and accumulates it. On
//   the last word of a frame, stage 2 loads a registered result (ones total,
//   word total and a saturation flag) onto a valid/ready output.
//
//   Parameters
//     DW : input word width. Must be a multiple of 8, in the range 8..64.
//     CW : width of the out_count / out_words accumulators.
//
//   Ports
//     clk       : sole clock, rising edge
//     rst_n     : asynchronous active-low reset
//     in_valid  : input word present
//     in_ready  : block accepts a word this cycle
//     in_data   : word to count
//     in_last   : final word of the current frame
//     out_valid : frame result held
//     out_ready : consumer accepts the result
//     out_count : set bits in the frame, saturating at 2^CW-1
//     out_words : words in the frame, saturating at 2^CW-1
//     out_sat   : out_count or out_words was clipped
// -----------------------------------------------------------------------------
module popcount_accum #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_count,
  output logic [CW-1:0] out_words,
  output logic          out_sat
);

  localparam int NB = DW / 8;           // bytes per word
  localparam int SW = $clog2(DW + 1);   // width of one word's ones count
  localparam int AW = CW + 1;           // one spare bit to detect overflow

  // Ones count of a single byte (0..8).
  function automatic logic [3:0] ones8(input logic [7:0] b);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, b[i]};
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // Global advance enable. The whole pipeline moves only when the output
  // register is free or being drained this cycle, so a stalled result
  // freezes stage 1 and the accumulator as well.
  // ---------------------------------------------------------------------------
  logic en;
  logic transfer;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign transfer = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Stage 1: per-byte ones counts
  // ---------------------------------------------------------------------------
  logic       s1_valid;
  logic       s1_last;
  logic [3:0] s1_byte [NB];

  // NOTE: s1_byte is a small register array, not a RAM, so it is cleared with
  // the rest of the pipeline; leaving it unreset would let stale counts leak
  // into X-propagation checks after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      for (int k = 0; k < NB; k++) s1_byte[k] <= '0;
    end else if (en) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values; blocking here would chain stages in one cycle.
      s1_valid <= transfer;
      s1_last  <= in_last;
      for (int k = 0; k < NB; k++) s1_byte[k] <= ones8(in_data[8*k +: 8]);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: word sum, saturating accumulate
  // ---------------------------------------------------------------------------
  logic [CW-1:0] acc_count;
  logic [CW-1:0] acc_words;
  logic          acc_sat;

  logic [SW-1:0] wsum;
  logic [AW-1:0] nacc;
  logic [AW-1:0] nwords;
  logic [CW-1:0] cnt_clamp;
  logic [CW-1:0] words_clamp;
  logic          sat_next;

  // NOTE: wsum is assigned a default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wsum = '0;
    for (int k = 0; k < NB; k++) wsum = wsum + SW'(s1_byte[k]);
  end

  assign nacc        = AW'(acc_count) + AW'(wsum);
  assign nwords      = AW'(acc_words) + AW'(1);
  assign cnt_clamp   = nacc[CW]   ? '1 : nacc[CW-1:0];
  assign words_clamp = nwords[CW] ? '1 : nwords[CW-1:0];
  // Sticky: a clip earlier in the frame still marks the frame result.
  assign sat_next    = acc_sat || nacc[CW] || nwords[CW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_count <= '0;
      acc_words <= '0;
      acc_sat   <= 1'b0;
      out_valid <= 1'b0;
      out_count <= '0;
      out_words <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      if (s1_valid && s1_last) begin
        // The last word goes straight to the output and the accumulator is
        // cleared, so the next frame's first word can follow with no gap.
        out_count <= cnt_clamp;
        out_words <= words_clamp;
        out_sat   <= sat_next;
        out_valid <= 1'b1;
        acc_count <= '0;
        acc_words <= '0;
        acc_sat   <= 1'b0;
      end else begin
        // en implies any held result is being drained this edge.
        out_valid <= 1'b0;
        if (s1_valid) begin
          acc_count <= cnt_clamp;
          acc_words <= words_clamp;
          acc_sat   <= sat_next;
        end
      end
    end
  end

endmodule
